// File: rtl/vex_issue_seq.sv
// Vector issue sequencer: splits one vector instruction into lane-array beats of up to
// VECTOR_LANES elements each and pulses a completion carrying the instruction ticket.
module vex_issue_seq #(
    parameter int unsigned MICROOP_WIDTH      = 5,
    parameter int unsigned VECTOR_TICKET_BITS = 4,
    parameter int unsigned VECTOR_LANES       = 8,
    parameter int unsigned VL_BITS            = 7
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,

    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [4:0]                    in_dst_i,
    input  logic [VECTOR_TICKET_BITS-1:0] in_ticket_i,
    input  logic [MICROOP_WIDTH-1:0]      in_microop_i,
    input  logic [1:0]                    in_fu_i,
    input  logic [VL_BITS-1:0]            in_vl_i,

    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [VECTOR_LANES-1:0]       out_lane_en_o,
    output logic [4:0]                    out_dst_o,
    output logic [VECTOR_TICKET_BITS-1:0] out_ticket_o,
    output logic [MICROOP_WIDTH-1:0]      out_microop_o,
    output logic [1:0]                    out_fu_o,
    output logic [VL_BITS-1:0]            out_elem_base_o,
    output logic                          out_last_o,

    output logic                          done_valid_o,
    output logic [VECTOR_TICKET_BITS-1:0] done_ticket_o,
    output logic                          busy_o
);

    typedef enum logic [0:0] {
        StIdle,
        StIssue
    } state_e;

    state_e                        state_q, state_d;
    logic [4:0]                    dst_q, dst_d;
    logic [VECTOR_TICKET_BITS-1:0] ticket_q, ticket_d;
    logic [MICROOP_WIDTH-1:0]      microop_q, microop_d;
    logic [1:0]                    fu_q, fu_d;
    logic [VL_BITS-1:0]            vl_q, vl_d;
    logic [VL_BITS-1:0]            remaining_q, remaining_d;
    // Beat counter only feeds the destination register, so mod-32 wrap is exactly what is wanted.
    logic [4:0]                    beat_q, beat_d;
    logic                          done_valid_q, done_valid_d;
    logic [VECTOR_TICKET_BITS-1:0] done_ticket_q, done_ticket_d;

    logic                          beat_last;
    logic [VL_BITS-1:0]            remaining_step;
    logic [VECTOR_LANES-1:0]       lane_en;

    always_comb begin
        beat_last      = 32'(remaining_q) <= VECTOR_LANES;
        remaining_step = beat_last ? '0 : remaining_q - VL_BITS'(VECTOR_LANES);
        for (int unsigned i = 0; i < VECTOR_LANES; i++) begin
            lane_en[i] = 32'(remaining_q) > i;
        end
    end

    always_comb begin
        state_d       = state_q;
        dst_d         = dst_q;
        ticket_d      = ticket_q;
        microop_d     = microop_q;
        fu_d          = fu_q;
        vl_d          = vl_q;
        remaining_d   = remaining_q;
        beat_d        = beat_q;
        done_valid_d  = 1'b0;
        done_ticket_d = done_ticket_q;

        in_ready_o      = 1'b0;
        out_valid_o     = 1'b0;
        busy_o          = 1'b0;
        out_lane_en_o   = '0;
        out_dst_o       = '0;
        out_ticket_o    = '0;
        out_microop_o   = '0;
        out_fu_o        = '0;
        out_elem_base_o = '0;
        out_last_o      = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready_o = ~flush;
                if (in_valid_i && !flush) begin
                    dst_d       = in_dst_i;
                    ticket_d    = in_ticket_i;
                    microop_d   = in_microop_i;
                    fu_d        = in_fu_i;
                    vl_d        = in_vl_i;
                    remaining_d = in_vl_i;
                    beat_d      = '0;
                    if (in_vl_i != '0) begin
                        state_d = StIssue;
                    end else begin
                        // Zero-length instruction completes without touching the lanes.
                        done_valid_d  = 1'b1;
                        done_ticket_d = in_ticket_i;
                    end
                end
            end
            StIssue: begin
                out_valid_o     = 1'b1;
                busy_o          = 1'b1;
                out_lane_en_o   = lane_en;
                out_dst_o       = dst_q + beat_q;
                out_ticket_o    = ticket_q;
                out_microop_o   = microop_q;
                out_fu_o        = fu_q;
                out_elem_base_o = vl_q - remaining_q;
                out_last_o      = beat_last;
                if (flush) begin
                    // A beat handshaken alongside flush is killed: no completion.
                    state_d = StIdle;
                end else if (out_ready_i) begin
                    remaining_d = remaining_step;
                    beat_d      = beat_q + 5'd1;
                    if (beat_last) begin
                        state_d       = StIdle;
                        done_valid_d  = 1'b1;
                        done_ticket_d = ticket_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            dst_q         <= '0;
            ticket_q      <= '0;
            microop_q     <= '0;
            fu_q          <= '0;
            vl_q          <= '0;
            remaining_q   <= '0;
            beat_q        <= '0;
            done_valid_q  <= 1'b0;
            done_ticket_q <= '0;
        end else begin
            state_q       <= state_d;
            dst_q         <= dst_d;
            ticket_q      <= ticket_d;
            microop_q     <= microop_d;
            fu_q          <= fu_d;
            vl_q          <= vl_d;
            remaining_q   <= remaining_d;
            beat_q        <= beat_d;
            done_valid_q  <= done_valid_d;
            done_ticket_q <= done_ticket_d;
        end
    end

    assign done_valid_o  = done_valid_q;
    assign done_ticket_o = done_ticket_q;

endmodule

// File: tb/tb_vex_issue_seq.sv
// Bench for vex_issue_seq: directed scenarios plus randomized instructions checked against
// a beat-list reference model derived from vl, dst and the lane count.
module tb_vex_issue_seq;

    localparam int unsigned L  = 8;
    localparam int unsigned MW = 5;
    localparam int unsigned TW = 4;
    localparam int unsigned VB = 7;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready_o;
    logic [4:0]    in_dst;
    logic [TW-1:0] in_ticket;
    logic [MW-1:0] in_microop;
    logic [1:0]    in_fu;
    logic [VB-1:0] in_vl;
    logic          out_valid_o;
    logic          out_ready;
    logic [L-1:0]  out_lane_en_o;
    logic [4:0]    out_dst_o;
    logic [TW-1:0] out_ticket_o;
    logic [MW-1:0] out_microop_o;
    logic [1:0]    out_fu_o;
    logic [VB-1:0] out_elem_base_o;
    logic          out_last_o;
    logic          done_valid_o;
    logic [TW-1:0] done_ticket_o;
    logic          busy_o;

    int            checks = 0;
    int            errors = 0;
    logic [TW-1:0] last_done;

    vex_issue_seq #(
        .MICROOP_WIDTH      (MW),
        .VECTOR_TICKET_BITS (TW),
        .VECTOR_LANES       (L),
        .VL_BITS            (VB)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready_o),
        .in_dst_i        (in_dst),
        .in_ticket_i     (in_ticket),
        .in_microop_i    (in_microop),
        .in_fu_i         (in_fu),
        .in_vl_i         (in_vl),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready),
        .out_lane_en_o   (out_lane_en_o),
        .out_dst_o       (out_dst_o),
        .out_ticket_o    (out_ticket_o),
        .out_microop_o   (out_microop_o),
        .out_fu_o        (out_fu_o),
        .out_elem_base_o (out_elem_base_o),
        .out_last_o      (out_last_o),
        .done_valid_o    (done_valid_o),
        .done_ticket_o   (done_ticket_o),
        .busy_o          (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Random payload on every input; in_valid low and flush low unless the caller overrides.
    task automatic idle_inputs();
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_dst     = 5'($urandom);
        in_ticket  = TW'($urandom);
        in_microop = MW'($urandom);
        in_fu      = 2'($urandom);
        in_vl      = VB'($urandom);
        out_ready  = 1'($urandom);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_oval"}, out_valid_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_lane"}, out_lane_en_o, 0);
        chk({tag, "_dst"}, out_dst_o, 0);
        chk({tag, "_base"}, out_elem_base_o, 0);
        chk({tag, "_last"}, out_last_o, 0);
        chk({tag, "_tkt"}, out_ticket_o, 0);
        chk({tag, "_mop"}, out_microop_o, 0);
        chk({tag, "_fu"}, out_fu_o, 0);
        chk({tag, "_dval"}, done_valid_o, 0);
        chk({tag, "_dtkt"}, done_ticket_o, 0);
    endtask

    // Issue one instruction and follow it to completion (or flush at beat flush_beat).
    task automatic run_instr(input int vl, input int dst, input int tkt, input int stall0,
                             input int pct, input int flush_beat);
        int            nb;
        int            b;
        int            stalls;
        int            cyc;
        int            rem;
        int            n;
        logic          rdy;
        logic [MW-1:0] mop;
        logic [1:0]    fu;
        nb     = (vl + L - 1) / L;
        b      = 0;
        stalls = 0;
        cyc    = 0;
        mop    = MW'($urandom);
        fu     = 2'($urandom);

        @(negedge clk);
        idle_inputs();
        in_valid   = 1'b1;
        in_dst     = 5'(dst);
        in_ticket  = TW'(tkt);
        in_microop = mop;
        in_fu      = fu;
        in_vl      = VB'(vl);
        #1;
        chk("acc_ready", in_ready_o, 1);
        chk("acc_oval", out_valid_o, 0);
        chk("acc_busy", busy_o, 0);

        if (vl == 0) begin
            @(negedge clk);
            idle_inputs();
            #1;
            chk("vl0_dval", done_valid_o, 1);
            chk("vl0_dtkt", done_ticket_o, tkt);
            chk("vl0_oval", out_valid_o, 0);
            chk("vl0_ready", in_ready_o, 1);
            last_done = TW'(tkt);
            @(negedge clk);
            #1;
            chk("vl0_dval_off", done_valid_o, 0);
            return;
        end

        while (b < nb) begin
            @(negedge clk);
            idle_inputs();
            in_valid = 1'($urandom);
            if (b == 0 && stalls < stall0) begin
                rdy = 1'b0;
                stalls++;
            end else begin
                rdy = ($urandom_range(99) < pct);
            end
            out_ready = rdy;
            if (b == flush_beat) flush = 1'b1;
            #1;
            rem = vl - b * L;
            n   = (rem > L) ? L : rem;
            chk("oval", out_valid_o, 1);
            chk("busy", busy_o, 1);
            chk("iready", in_ready_o, 0);
            chk("lane_en", out_lane_en_o, (32'd1 << n) - 32'd1);
            chk("dst", out_dst_o, (dst + b) % 32);
            chk("base", out_elem_base_o, b * L);
            chk("last", out_last_o, (rem <= L) ? 1 : 0);
            chk("tkt", out_ticket_o, tkt);
            chk("mop", out_microop_o, mop);
            chk("fu", out_fu_o, fu);
            chk("dval_busy", done_valid_o, 0);
            chk("dtkt_hold", done_ticket_o, last_done);
            if (flush) begin
                @(negedge clk);
                idle_inputs();
                #1;
                chk("fl_oval", out_valid_o, 0);
                chk("fl_busy", busy_o, 0);
                chk("fl_ready", in_ready_o, 1);
                chk("fl_dval", done_valid_o, 0);
                @(negedge clk);
                #1;
                chk("fl_dval2", done_valid_o, 0);
                return;
            end
            if (rdy) b++;
            cyc++;
            if (cyc > 400) begin
                checks++;
                errors++;
                $error("FAIL timeout: observed %0d beats expected %0d", b, nb);
                return;
            end
        end

        @(negedge clk);
        idle_inputs();
        #1;
        chk("done_val", done_valid_o, 1);
        chk("done_tkt", done_ticket_o, tkt);
        chk("done_ready", in_ready_o, 1);
        chk("done_oval", out_valid_o, 0);
        chk("done_busy", busy_o, 0);
        last_done = TW'(tkt);
        @(negedge clk);
        #1;
        chk("done_off", done_valid_o, 0);
        chk("done_hold", done_ticket_o, tkt);
    endtask

    initial begin
        rst       = 1'b1;
        last_done = '0;
        idle_inputs();
        repeat (3) @(negedge clk);
        #1;
        chk_all_zero("rst");
        chk("rst_ready", in_ready_o, 1);
        @(negedge clk);
        rst = 1'b0;

        run_instr(8, 4, 3, 0, 100, -1);
        run_instr(19, 4, 2, 0, 100, -1);
        run_instr(16, 10, 7, 3, 100, -1);
        run_instr(0, 1, 9, 0, 100, -1);
        run_instr(24, 12, 5, 0, 100, 1);
        run_instr(8, 20, 11, 0, 100, -1);
        run_instr(16, 31, 6, 0, 100, -1);

        // Flush in IDLE blocks an accept (a vl=0 accept would otherwise pulse done).
        @(negedge clk);
        idle_inputs();
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_vl     = '0;
        in_ticket = 4'd13;
        #1;
        chk("idlefl_ready", in_ready_o, 0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("idlefl_dval", done_valid_o, 0);
        chk("idlefl_busy", busy_o, 0);

        // A registered done pulse survives a flush in the following cycle.
        @(negedge clk);
        idle_inputs();
        in_valid  = 1'b1;
        in_vl     = '0;
        in_ticket = 4'd6;
        @(negedge clk);
        idle_inputs();
        flush = 1'b1;
        #1;
        chk("pendfl_dval", done_valid_o, 1);
        chk("pendfl_dtkt", done_ticket_o, 6);
        chk("pendfl_ready", in_ready_o, 0);
        last_done = 4'd6;
        @(negedge clk);
        idle_inputs();

        // Reset mid-instruction.
        @(negedge clk);
        idle_inputs();
        in_valid  = 1'b1;
        in_vl     = 7'd24;
        in_dst    = 5'd7;
        in_ticket = 4'd5;
        @(negedge clk);
        idle_inputs();
        out_ready = 1'b1;
        #1;
        chk("mid_oval", out_valid_o, 1);
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        #1;
        chk_all_zero("midrst");
        chk("midrst_ready", in_ready_o, 1);
        last_done = '0;

        for (int k = 0; k < 30; k++) begin
            run_instr(int'($urandom_range(127)), int'($urandom_range(31)),
                      int'($urandom_range(15)), int'($urandom_range(2)),
                      int'($urandom_range(100, 30)),
                      ($urandom_range(9) == 0) ? int'($urandom_range(3)) : -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vex_issue_seq.md
Name: vex_issue_seq

Overview:
- Sequences one vector instruction into per-beat issues for the vex lane array; each beat covers up to VECTOR_LANES elements.
- Sits between the vector issue stage and vex; out_ready_i connects to vex ready_o.
- Produces per-beat lane enables, element base index, destination register (advancing one register per beat) and a completion pulse carrying the instruction ticket.
- Operand fetch uses out_elem_base_o and is outside this block.

Parameters:
- MICROOP_WIDTH, 5, micro-op field width.
- VECTOR_TICKET_BITS, 4, ticket width.
- VECTOR_LANES, 8, elements per beat; must be a power of two, at least 2.
- VL_BITS, 7, vl width; legal vl is 0..2^VL_BITS-1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of the in-flight instruction.
- in_valid_i  in  1  instruction valid.
- in_ready_o  out  1  sequencer can accept.
- in_dst_i  in  5  base destination register.
- in_ticket_i  in  VECTOR_TICKET_BITS  instruction ticket.
- in_microop_i  in  MICROOP_WIDTH  micro-op.
- in_fu_i  in  2  functional unit select.
- in_vl_i  in  VL_BITS  vector length in elements.
- out_valid_o  out  1  beat valid to vex.
- out_ready_i  in  1  vex ready.
- out_lane_en_o  out  VECTOR_LANES  per-lane valid.
- out_dst_o  out  5  destination register for this beat.
- out_ticket_o  out  VECTOR_TICKET_BITS  latched ticket.
- out_microop_o  out  MICROOP_WIDTH  latched micro-op.
- out_fu_o  out  2  latched fu.
- out_elem_base_o  out  VL_BITS  index of this beat's lane 0 element.
- out_last_o  out  1  final beat of the instruction.
- done_valid_o  out  1  one-cycle completion pulse.
- done_ticket_o  out  VECTOR_TICKET_BITS  ticket of the completed instruction.
- busy_o  out  1  high while state is ISSUE.

Behaviour:
- FSM states: IDLE, ISSUE. All state is registered.
- Reset (rst=1 at a clock edge):
  - state=IDLE.
  - All out_* and done_* outputs are 0, and all internal counters and latched fields are 0.
  - Reset has priority over flush and over accept, including mid-instruction.
- IDLE:
  - in_ready_o = ~flush; out_valid_o=0; busy_o=0.
  - Accept = in_valid_i & in_ready_o.
  - On accept, latch dst, ticket, microop, fu and vl; set remaining=vl, beat=0.
  - If vl>0, go to ISSUE, so out_valid_o rises the cycle after accept.
  - If vl=0, stay in IDLE, issue no beats, and raise done_valid_o the cycle after accept.
- ISSUE:
  - in_ready_o=0; out_valid_o=1; busy_o=1.
  - out_lane_en_o: the low min(remaining, VECTOR_LANES) bits are set, the rest are 0.
  - out_elem_base_o = beat*VECTOR_LANES, which equals vl_latched - remaining.
  - out_dst_o = (dst_latched + beat) mod 32; wraps 31 -> 0.
  - out_last_o = (remaining <= VECTOR_LANES).
  - On out_valid_o & out_ready_i: remaining -= VECTOR_LANES (saturating at 0) and beat += 1.
    - If that beat was last: go to IDLE and raise done_valid_o the next cycle with done_ticket_o = ticket.
  - While out_ready_i=0, every out_* output holds stable (valid/ready rule; no retraction).
- Beat count is ceil(vl/VECTOR_LANES). Back-to-back instructions have a minimum 1-cycle IDLE gap after the last beat.
- done_valid_o:
  - Asserted for exactly 1 cycle per completed instruction.
  - done_ticket_o holds its value until the next done pulse.
- flush:
  - In ISSUE: go to IDLE next cycle, out_valid_o=0, no done pulse. A beat handshaken in the same cycle as flush is considered killed and produces no done pulse.
  - In IDLE: in_ready_o=0, so no accept occurs that cycle.
  - A pending done pulse that was already registered before the flush cycle still fires.
- Latched fields ignore in_* while busy.

Test Plan:
1. VECTOR_LANES=8, vl=8, dst=4, ticket=3, out_ready_i=1.
   - Exactly one beat: lane_en=0xFF, dst=4, elem_base=0, last=1.
   - done_valid_o pulses with done_ticket_o=3 one cycle after the handshake.
   - in_ready_o is high again that cycle.
2. vl=19, dst=4.
   - Three beats: lane_en=0xFF/0xFF/0x07; dst=4/5/6; elem_base=0/8/16; last=0/0/1.
   - One done pulse.
3. vl=16, out_ready_i low for 3 cycles during beat 0.
   - out_valid_o, lane_en, dst and elem_base are held unchanged for those 3 cycles.
   - Beat 1 is issued only after ready returns; total of 2 handshakes.
4. vl=0, ticket=9.
   - out_valid_o never asserts.
   - done_valid_o=1 with done_ticket_o=9 one cycle after accept.
   - in_ready_o stays 1.
5. vl=24, flush asserted during beat 1.
   - Next cycle out_valid_o=0, busy_o=0, in_ready_o=1.
   - No done pulse.
   - A following vl=8 instruction then sequences normally.
6. dst=31, vl=16.
   - Beat dst values are 31, 0.
   - Separately, rst asserted mid-beat: the next cycle all outputs are 0, state is IDLE, and in_ready_o=1.
